// File: rtl/fixed_ascii_pkg.sv
// rtl/fixed_ascii_pkg.sv - shared constants, state encoding and constant helpers for the ASCII converter
package fixed_ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SP    = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_INT,
    S_FRAC,
    S_DONE
  } state_t;

  // 10^n as a 64-bit constant; digit counts stay well below 20
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // round(2^fb / (2*10^fd)): half of one unit of the last displayed digit
  function automatic longint unsigned round_const(input int fb, input int fd);
    return ((64'd1 << fb) + pow10(fd)) / (64'd2 * pow10(fd));
  endfunction

endpackage

// File: rtl/decimal_digit_step.sv
// rtl/decimal_digit_step.sv - one decimal digit step: integer div/mod by 10 and fraction multiply by 10
module decimal_digit_step #(
  parameter int IW = 4,
  parameter int FW = 30
) (
  input  logic [IW-1:0] int_in,
  output logic [IW-1:0] int_quot,
  output logic [3:0]    int_digit,
  input  logic [FW-1:0] frac_in,
  output logic [FW-1:0] frac_out,
  output logic [3:0]    frac_digit
);

  logic [FW+3:0] prod;

  // integer side peels the least significant digit, fraction side produces the most significant one
  always_comb begin
    int_quot   = int_in / IW'(10);
    int_digit  = 4'(int_in % IW'(10));
    prod       = {4'b0000, frac_in} * (FW+4)'(10);
    frac_digit = prod[FW+3:FW];
    frac_out   = prod[FW-1:0];
  end

endmodule

// File: rtl/fixed_to_ascii_converter.sv
// rtl/fixed_to_ascii_converter.sv - sequential signed fixed-point to ASCII decimal converter
module fixed_to_ascii_converter
  import fixed_ascii_pkg::*;
#(
  parameter int INT_BITS    = 3,
  parameter int FRAC_BITS   = 30,
  parameter int INT_DIGITS  = 2,
  parameter int FRAC_DIGITS = 4,
  parameter int ROUND       = 0,
  parameter int ZERO_PAD    = 1,
  localparam int BITS       = INT_BITS + FRAC_BITS,
  localparam int NUM_CHARS  = INT_DIGITS + FRAC_DIGITS + 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [BITS-1:0]        i_value,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NUM_CHARS*8-1:0] o_chars,
  output logic                   o_overflow
);

  function automatic logic [NUM_CHARS*8-1:0] reset_chars();
    logic [NUM_CHARS*8-1:0] r;
    for (int c = 0; c < NUM_CHARS; c++) r[8*c +: 8] = ASCII_0;
    r[8*(NUM_CHARS-1) +: 8] = ASCII_PLUS;
    r[8*FRAC_DIGITS +: 8]   = ASCII_DOT;
    return r;
  endfunction

  localparam logic [NUM_CHARS*8-1:0] RESET_CHARS = reset_chars();
  localparam logic [BITS:0]          RC_ADD      = (ROUND != 0) ? (BITS+1)'(round_const(FRAC_BITS, FRAC_DIGITS)) : '0;
  localparam longint unsigned        INT_LIMIT   = pow10(INT_DIGITS);

  state_t                 state_q, state_d;
  logic                   sign_q;
  logic [BITS-1:0]        mag_q;
  logic [INT_BITS:0]      iv_q;
  logic [FRAC_BITS-1:0]   fv_q;
  logic                   ovf_q;
  logic [7:0]             cnt_q;
  logic [NUM_CHARS*8-1:0] buf_q;

  logic [BITS:0]          rounded;
  logic [INT_BITS:0]      int_quot;
  logic [3:0]             int_digit;
  logic [FRAC_BITS-1:0]   frac_next;
  logic [3:0]             frac_digit;
  logic [7:0]             int_char;
  logic [7:0]             frac_char;
  logic                   int_last;
  logic                   frac_last;

  decimal_digit_step #(
    .IW (INT_BITS + 1),
    .FW (FRAC_BITS)
  ) u_step (
    .int_in     (iv_q),
    .int_quot   (int_quot),
    .int_digit  (int_digit),
    .frac_in    (fv_q),
    .frac_out   (frac_next),
    .frac_digit (frac_digit)
  );

  // digit characters, with saturation and optional blanking of leading integer zeros
  always_comb begin
    rounded   = {1'b0, mag_q} + RC_ADD;
    int_last  = (cnt_q == 8'(INT_DIGITS - 1));
    frac_last = (cnt_q == 8'(FRAC_DIGITS - 1));
    if (ovf_q)
      int_char = ASCII_9;
    else if (ZERO_PAD == 0 && cnt_q != 8'd0 && int_quot == '0 && int_digit == 4'd0)
      int_char = ASCII_SP;
    else
      int_char = ASCII_0 + {4'b0000, int_digit};
    frac_char = ovf_q ? ASCII_9 : ASCII_0 + {4'b0000, frac_digit};
  end

  assign o_ready = (state_q == S_IDLE);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state: the result is held in DONE until the consumer takes it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid) state_d = S_PREP;
      S_PREP:  state_d = S_INT;
      S_INT:   if (int_last) state_d = S_FRAC;
      S_FRAC:  if (frac_last) state_d = S_DONE;
      S_DONE:  if (o_valid && i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath: capture, split, digit generation, then publish the assembled string
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q     <= 1'b0;
      mag_q      <= '0;
      iv_q       <= '0;
      fv_q       <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= 8'd0;
      buf_q      <= RESET_CHARS;
      o_chars    <= RESET_CHARS;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            sign_q <= i_value[BITS-1];
            mag_q  <= i_value[BITS-1] ? (~i_value + BITS'(1)) : i_value;
          end
        end
        S_PREP: begin
          iv_q  <= rounded[BITS:FRAC_BITS];
          fv_q  <= rounded[FRAC_BITS-1:0];
          ovf_q <= (64'(rounded[BITS:FRAC_BITS]) >= INT_LIMIT);
          cnt_q <= 8'd0;
          buf_q[8*(NUM_CHARS-1) +: 8] <= sign_q ? ASCII_MINUS : ASCII_PLUS;
          buf_q[8*FRAC_DIGITS +: 8]   <= ASCII_DOT;
        end
        S_INT: begin
          buf_q[8*(FRAC_DIGITS + 1 + int'(cnt_q)) +: 8] <= int_char;
          iv_q  <= int_quot;
          cnt_q <= int_last ? 8'd0 : cnt_q + 8'd1;
        end
        S_FRAC: begin
          buf_q[8*(FRAC_DIGITS - 1 - int'(cnt_q)) +: 8] <= frac_char;
          fv_q  <= frac_next;
          cnt_q <= cnt_q + 8'd1;
        end
        S_DONE: begin
          if (!o_valid) begin
            o_chars    <= buf_q;
            o_overflow <= ovf_q;
            o_valid    <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_ascii_converter.sv
// tb/tb_fixed_to_ascii_converter.sv - directed scoreboard bench for the fixed-point to ASCII converter
module tb_fixed_to_ascii_converter;

  typedef struct {
    int          k;
    logic [71:0] chars;
    logic        ovf;
  } exp_t;

  logic        w_clk_pxl = 1'b0;
  logic        rst_n;
  logic [37:0] val;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_ready [4];
  logic        out_valid [4];
  logic        out_ovf   [4];
  logic [63:0] ch0, ch1, ch2;
  logic [71:0] ch3;
  int          lat [4] = '{8, 8, 8, 9};
  int          total = 0;
  int          bad = 0;
  exp_t        sb [$];

  always #5 w_clk_pxl = ~w_clk_pxl;

  fixed_to_ascii_converter u_def (
    .i_clk(w_clk_pxl), .i_rst_n(rst_n), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_value(val[32:0]), .o_valid(out_valid[0]), .i_ready(in_ready[0]), .o_chars(ch0),
    .o_overflow(out_ovf[0]));

  fixed_to_ascii_converter #(.ROUND(1)) u_rnd (
    .i_clk(w_clk_pxl), .i_rst_n(rst_n), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_value(val[32:0]), .o_valid(out_valid[1]), .i_ready(in_ready[1]), .o_chars(ch1),
    .o_overflow(out_ovf[1]));

  fixed_to_ascii_converter #(.INT_BITS(8)) u_ovf (
    .i_clk(w_clk_pxl), .i_rst_n(rst_n), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
    .i_value(val), .o_valid(out_valid[2]), .i_ready(in_ready[2]), .o_chars(ch2),
    .o_overflow(out_ovf[2]));

  fixed_to_ascii_converter #(.INT_BITS(8), .INT_DIGITS(3), .ZERO_PAD(0)) u_zp (
    .i_clk(w_clk_pxl), .i_rst_n(rst_n), .i_valid(in_valid[3]), .o_ready(out_ready[3]),
    .i_value(val), .o_valid(out_valid[3]), .i_ready(in_ready[3]), .o_chars(ch3),
    .o_overflow(out_ovf[3]));

  function automatic logic [71:0] chars_of(input int k);
    case (k)
      0:       return 72'(ch0);
      1:       return 72'(ch1);
      2:       return 72'(ch2);
      default: return ch3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h (%s) expected=%h (%s)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic convert(input int k, input logic [37:0] v, input logic [71:0] exp_chars,
                         input logic exp_ovf, input int hold);
    exp_t        e;
    int          n;
    logic [71:0] snap;
    logic        stable;
    e.k = k; e.chars = exp_chars; e.ovf = exp_ovf;
    sb.push_back(e);
    @(negedge w_clk_pxl);
    check("ready_before_accept", 72'(out_ready[k]), 72'(1));
    val = v;
    in_valid[k] = 1'b1;
    @(posedge w_clk_pxl);
    #1 in_valid[k] = 1'b0;
    n = 0;
    while (!out_valid[k] && n < 50) begin
      @(posedge w_clk_pxl);
      #1 n++;
    end
    check("latency", 72'(n), 72'(lat[k]));
    e = sb.pop_front();
    check("chars", chars_of(e.k), e.chars);
    check("overflow", 72'(out_ovf[e.k]), 72'(e.ovf));
    if (hold > 0) begin
      snap = chars_of(k);
      stable = 1'b1;
      val = 38'h0_4000_0000;
      in_valid[k] = 1'b1;
      repeat (hold) begin
        @(posedge w_clk_pxl);
        #1;
        if (!out_valid[k] || out_ready[k] || chars_of(k) !== snap) stable = 1'b0;
      end
      in_valid[k] = 1'b0;
      check("backpressure_stable", 72'(stable), 72'(1));
    end
    in_ready[k] = 1'b1;
    @(posedge w_clk_pxl);
    #1 in_ready[k] = 1'b0;
    check("valid_after_take", 72'(out_valid[k]), 72'(0));
    check("ready_after_take", 72'(out_ready[k]), 72'(1));
  endtask

  initial begin
    logic [71:0] rs;
    rst_n = 1'b0;
    val = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      in_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      rs = (i == 3) ? 72'("+000.0000") : 72'("+00.0000");
      check("reset_chars", chars_of(i), rs);
      check("reset_ready", 72'(out_ready[i]), 72'(1));
      check("reset_valid", 72'(out_valid[i]), 72'(0));
      check("reset_ovf", 72'(out_ovf[i]), 72'(0));
    end
    @(negedge w_clk_pxl);
    rst_n = 1'b1;

    convert(0, 38'h0_31EB_851E, "+00.7799", 1'b0, 0);
    convert(1, 38'h0_31EB_851E, "+00.7800", 1'b0, 0);
    convert(0, 38'h1_A000_0000, "-01.5000", 1'b0, 0);
    convert(0, 38'h1_0000_0000, "-04.0000", 1'b0, 0);
    convert(2, 38'h19_1000_0000, "+99.9999", 1'b1, 0);
    convert(2, 38'h0_2000_0000, "+00.5000", 1'b0, 0);
    convert(3, 38'h1_C000_0000, "+  7.0000", 1'b0, 0);
    convert(3, 38'h0, "+  0.0000", 1'b0, 0);

    convert(0, 38'h0_31EB_851E, "+00.7799", 1'b0, 20);
    repeat (3) @(posedge w_clk_pxl);
    #1 check("no_queued_accept", 72'(out_valid[0]), 72'(0));
    check("idle_after_backpressure", 72'(out_ready[0]), 72'(1));

    @(negedge w_clk_pxl);
    val = 38'h0_4000_0000;
    in_valid[0] = 1'b1;
    @(posedge w_clk_pxl);
    #1 in_valid[0] = 1'b0;
    repeat (5) @(posedge w_clk_pxl);
    #1 check("prev_result_kept", chars_of(0), "+00.7799");
    check("busy_not_ready", 72'(out_ready[0]), 72'(0));
    rst_n = 1'b0;
    #1 check("midreset_chars", chars_of(0), "+00.0000");
    check("midreset_ready", 72'(out_ready[0]), 72'(1));
    check("midreset_valid", 72'(out_valid[0]), 72'(0));
    @(negedge w_clk_pxl);
    rst_n = 1'b1;
    convert(0, 38'h0_5000_0000, "+01.2500", 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
